// File: rtl/div_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// div_pkg : state encoding, operand width and HI/LO field slices
//           shared by the divider issue control and its users.
// Revision: 1.0
// ------------------------------------------------------------------
package div_pkg;

  localparam int DIV_DW = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } div_state_e;

  // {HI, LO} = {remainder, quotient}
  localparam int LO_LSB = 0;
  localparam int LO_MSB = DIV_DW - 1;
  localparam int HI_LSB = DIV_DW;
  localparam int HI_MSB = 2 * DIV_DW - 1;

endpackage
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// div_issue_ctrl : EX-stage issue, stall and HI/LO write control for
//                  the multi-cycle divider. Option: DIV_ZERO_BYPASS_EN.
// Revision: 1.0
// ------------------------------------------------------------------
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_div_e,
  input  logic            sign_e,
  input  logic [DW-1:0]   src_a_e,
  input  logic [DW-1:0]   src_b_e,
  input  logic            flush_e,
  input  logic            flush_exception_m,
  output logic            div_valid,
  output logic [DW-1:0]   div_a,
  output logic [DW-1:0]   div_b,
  output logic            div_sign,
  input  logic            div_accept,
  input  logic            div_res_valid,
  output logic            div_res_ready,
  input  logic [2*DW-1:0] div_result,
  output logic            stall_div,
  output logic            hilo_we,
  output logic [2*DW-1:0] hilo_wdata
);

  div_state_e state, state_nxt;
  logic       issue;
  logic       zero_bypass;
  logic       stall_raw;

  assign issue = inst_div_e & ~flush_e;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_bypass = (src_b_e == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue) state_nxt = zero_bypass ? S_DONE : S_REQ;
      S_REQ: begin
        if (flush_e)         state_nxt = div_accept ? S_DRAIN : S_IDLE;
        else if (div_accept) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (div_res_valid)   state_nxt = flush_e ? S_IDLE : S_DONE;
        else if (flush_e)    state_nxt = S_DRAIN;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_DRAIN: if (div_res_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The request is withdrawn in a flush cycle so the divider never samples a
  // killed request; an accept already in flight is absorbed via DRAIN.
  always_comb begin
    div_valid     = 1'b0;
    div_res_ready = 1'b0;
    hilo_we       = 1'b0;
    stall_raw     = 1'b0;
    case (state)
      S_IDLE:  stall_raw = issue;
      S_REQ: begin
        div_valid = ~flush_e;
        stall_raw = 1'b1;
      end
      S_BUSY: begin
        div_res_ready = div_res_valid;
        stall_raw     = 1'b1;
      end
      S_DONE:  hilo_we = 1'b1;
      S_DRAIN: begin
        div_res_ready = div_res_valid;
        stall_raw     = inst_div_e;
      end
      default: ;
    endcase
    stall_div = stall_raw & ~flush_exception_m;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_a      <= '0;
      div_b      <= '0;
      div_sign   <= 1'b0;
      hilo_wdata <= '0;
    end else begin
      if (state == S_IDLE && issue) begin
        div_a    <= src_a_e;
        div_b    <= src_b_e;
        div_sign <= sign_e;
`ifdef DIV_ZERO_BYPASS_EN
        if (zero_bypass) hilo_wdata <= {src_a_e, {DW{1'b1}}};
`endif
      end
      if (state == S_BUSY && div_res_valid && !flush_e) hilo_wdata <= div_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_div_issue_ctrl : randomized bench for div_issue_ctrl with a model
//                     divider and a reference divide/flush model.
// Revision: 1.0
// ------------------------------------------------------------------
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int DW = DIV_DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_div_e, sign_e, flush_e, flush_exception_m;
  logic [DW-1:0]   src_a_e, src_b_e;
  logic            div_valid, div_sign, div_accept, div_res_valid, div_res_ready;
  logic [DW-1:0]   div_a, div_b;
  logic [2*DW-1:0] div_result, hilo_wdata;
  logic            stall_div, hilo_we;

  int n_cmp = 0;
  int n_bad = 0;
  int div_lat = 4;
  logic [2*DW-1:0] last_hilo = '0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .inst_div_e(inst_div_e), .sign_e(sign_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .flush_e(flush_e),
    .flush_exception_m(flush_exception_m), .div_valid(div_valid),
    .div_a(div_a), .div_b(div_b), .div_sign(div_sign), .div_accept(div_accept),
    .div_res_valid(div_res_valid), .div_res_ready(div_res_ready),
    .div_result(div_result), .stall_div(stall_div), .hilo_we(hilo_we),
    .hilo_wdata(hilo_wdata)
  );

  function automatic logic [2*DW-1:0] ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic s);
    logic [DW-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = DW'($signed(a) / $signed(b));
      r = DW'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Model divider: accept one cycle after sampling, result after div_lat more
  // cycles, held until consumed.
  logic [1:0] dv_st;
  int         dv_cnt;
  always @(posedge clk) begin
    if (rst) begin
      dv_st         <= 2'd0;
      dv_cnt        <= 0;
      div_accept    <= 1'b0;
      div_res_valid <= 1'b0;
      div_result    <= '0;
    end else begin
      div_accept <= 1'b0;
      case (dv_st)
        2'd0: if (div_valid) begin
          div_accept <= 1'b1;
          dv_cnt     <= div_lat;
          div_result <= ref_div(div_a, div_b, div_sign);
          dv_st      <= 2'd2;
        end
        2'd2: if (dv_cnt == 0) begin
          div_res_valid <= 1'b1;
          dv_st         <= 2'd3;
        end else dv_cnt <= dv_cnt - 1;
        2'd3: if (div_res_ready) begin
          div_res_valid <= 1'b0;
          dv_st         <= 2'd0;
        end
        default: dv_st <= 2'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // fmode: 0 none, 1 flush in first REQ cycle, 2 flush fdly cycles into BUSY,
  // 3 flush together with result, 4 exception mask in BUSY, 5 reset in BUSY.
  task automatic do_div(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                        input logic [2*DW-1:0] exp, input int fmode, input int fdly,
                        input int lat, input bit timed, input bit settle);
    int   cyc, n_we, we_cyc, post, t_we;
    bit   expect_we, bypass, stall_s, rst_chk, quiet;
    logic [2*DW-1:0] w;
    cyc = 0; n_we = 0; we_cyc = -1; post = 0; w = '0; rst_chk = 1'b0;
    div_lat   = lat;
    expect_we = (fmode == 0 || fmode == 4);
`ifdef DIV_ZERO_BYPASS_EN
    bypass = (b == '0);
`else
    bypass = 1'b0;
`endif
    t_we = bypass ? 1 : 4 + lat;
    inst_div_e = 1'b1; sign_e = s; src_a_e = a; src_b_e = b;
    while (1) begin
      if (cyc >= 400) begin
        check("timeout", 1, 0);
        break;
      end
      flush_e = 1'b0;
      flush_exception_m = 1'b0;
      case (fmode)
        1: flush_e = (cyc == 1);
        2: flush_e = (cyc == 3 + fdly);
        3: flush_e = div_res_valid;
        4: flush_exception_m = (cyc == 3 + fdly);
        5: rst = (cyc == 3 + fdly);
        default: ;
      endcase
      quiet = (dv_st == 2'd0) && !div_res_valid && !div_accept;
      @(negedge clk);
      if (hilo_we) begin
        n_we++;
        w = hilo_wdata;
        we_cyc = cyc;
        check("we_nostall", stall_div, 0);
      end
      if (bypass) check("bypass_novalid", div_valid, 0);
      if (rst_chk) begin
        check("rst_outs", {div_valid, div_res_ready, hilo_we, stall_div, div_sign}, 0);
        check("rst_ops", {div_a, div_b}, 0);
        check("rst_hilo", hilo_wdata, 0);
        rst_chk = 1'b0;
      end
      if (!inst_div_e && quiet && settle) begin
        check("idle_stall", stall_div, 0);
        check("idle_valid", div_valid, 0);
      end
      if (timed) begin
        if (cyc == 0) begin
          check("issue_stall", stall_div, 1);
          check("issue_novalid", div_valid, 0);
        end
        if (cyc == 1 && !bypass) begin
          check("req_valid", div_valid, !flush_e);
          check("req_a", div_a, a);
          check("req_b", div_b, b);
          check("req_sign", div_sign, s);
        end
        if (fmode == 0 && cyc < t_we) check("stall_hold", stall_div, 1);
        if (fmode == 3 && flush_e)    check("flush_res_ready", div_res_ready, 1);
        if (fmode == 4 && cyc == 3 + fdly) check("exc_mask", stall_div, 0);
        if (fmode == 4 && cyc == 4 + fdly) check("exc_busy", stall_div, 1);
      end
      stall_s = stall_div;
      @(posedge clk);
      #1;
      if (fmode == 5 && rst) begin
        rst = 1'b0;
        inst_div_e = 1'b0;
        rst_chk = 1'b1;
      end else if (flush_e) begin
        flush_e = 1'b0;
        inst_div_e = 1'b0;
      end else if (!stall_s) begin
        inst_div_e = 1'b0;
      end
      cyc++;
      if (!inst_div_e) begin
        if (!settle) break;
        quiet = (dv_st == 2'd0) && !div_res_valid && !div_accept;
        if (quiet && !rst_chk) post++;
        else post = 0;
        if (post == 3) break;
      end
    end
    flush_e = 1'b0;
    flush_exception_m = 1'b0;
    check("we_count", n_we, expect_we ? 1 : 0);
    if (expect_we) begin
      check("wdata", w, exp);
      if (settle) check("wdata_hold", hilo_wdata, exp);
      if (timed) check("we_latency", we_cyc, t_we);
      last_hilo = exp;
    end else if (fmode == 5) begin
      last_hilo = '0;
    end else if (settle) begin
      check("wdata_kept", hilo_wdata, last_hilo);
    end
  endtask

  initial begin
    rst = 1'b1; inst_div_e = 1'b0; sign_e = 1'b0; flush_e = 1'b0;
    flush_exception_m = 1'b0; src_a_e = '0; src_b_e = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {div_valid, div_res_ready, hilo_we, stall_div, div_sign}, 0);
    check("reset_ops", {div_a, div_b}, 0);
    check("reset_hilo", hilo_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0, 6, 1, 1);
    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 0, 32, 1, 1);
    do_div(32'd1234, 32'd5, 1'b0, 64'd0, 2, 10, 20, 1, 0);
    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0, 0, 5, 0, 1);
    do_div(32'd50, 32'd6, 1'b0, 64'd0, 3, 0, 4, 1, 1);
    do_div(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 4, 2, 8, 1, 1);
    do_div(32'd77, 32'd5, 1'b0, 64'd0, 1, 0, 4, 1, 1);
    do_div(32'd77, 32'd5, 1'b1, 64'd0, 5, 3, 8, 1, 1);
`ifdef DIV_ZERO_BYPASS_EN
    do_div(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 0, 0, 4, 1, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] ra, rb;
      logic          rs;
      int            fm, lat, fd;
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(1, 20)) : DW'($urandom);
      if (rb == '0) rb = 1;
      rs = 1'($urandom_range(0, 1));
      if (rs && ra == 32'h8000_0000 && rb == '1) rb = 3;
      lat = $urandom_range(2, 10);
      fm  = $urandom_range(0, 4);
      fd  = (fm == 4) ? $urandom_range(0, lat - 2) : $urandom_range(0, lat - 1);
      do_div(ra, rb, rs, ref_div(ra, rb, rs), fm, fd, lat, 1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
